rca_seq_adder: RTL and testbench
================================

// Module: rca_seq_adder
// PURPOSE
// Multi-cycle ripple-carry adder. Computes a + b + carry_in one SLICE-bit
// slice per clock, with the inter-slice carry held in a register. It is the
// addition counterpart of the subtractor chain: same slice arithmetic, but it
// adds, and it is sequential rather than a flat ripple. It sits behind a
// valid/ready input port and a valid/ready output port in the arithmetic datapath.
// PARAMETERS
// WIDTH  32  operand/result width in bits; must be a multiple of SLICE
// SLICE  8   bits summed per clock cycle; NSLICE = WIDTH/SLICE (>= 1)
// PORTS
// clk        in   1      clock, rising edge
// rst_n      in   1      synchronous reset, active low
// in_valid   in   1      operands and carry_in are valid
// in_ready   out  1      block can accept operands
// a          in   WIDTH  augend
// b          in   WIDTH  addend
// carry_in   in   1      carry into bit 0
// out_valid  out  1      sum, carry and overflow are valid
// out_ready  in   1      consumer takes the result
// sum        out  WIDTH  (a + b + carry_in) mod 2^WIDTH
// carry      out  1      carry out of bit WIDTH-1 (unsigned overflow)
// overflow   out  1      two's-complement signed overflow
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge) puts the FSM in IDLE and sets
//   sum=0, carry=0, overflow=0, out_valid=0, slice index=0 and the carry register to 0.
//   in_ready=1 in the first cycle after reset is released.
// - Reset during RUN or DONE abandons the operation. No result is produced.
// - The FSM has three states: IDLE -> RUN -> DONE -> IDLE.
// - IDLE: in_ready=1, out_valid=0. When in_valid&&in_ready at an edge:
//   * capture a, b and carry_in into internal registers;
//   * load the carry register with carry_in and set the slice index to 0;
//   * go to RUN.
// - RUN: in_ready=0. Each cycle, slice k = index computes
//   {c, s} = a[k] + b[k] + carry_reg (SLICE+1 bits).
//   s is written to sum[k*SLICE +: SLICE]; carry_reg <= c; index increments.
//   After slice NSLICE-1 the FSM goes to DONE.
// - Unwritten sum slices keep their previous value while in RUN.
//   They are not valid until out_valid=1.
// - DONE: out_valid=1, with carry = final carry_reg and
//   overflow = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
//   sum, carry and overflow hold stable until out_valid&&out_ready.
//   At that edge the FSM returns to IDLE.
// - Latency: the accept edge is edge 0. Slices are computed on edges 1..NSLICE.
//   out_valid is high after edge NSLICE, so it is visible NSLICE cycles after the accept.
// - Throughput is one result per NSLICE+2 cycles when out_ready is held high.
//   in_ready is not asserted in DONE; there is no overlap between operations.
// - Inputs a, b and carry_in are ignored whenever in_ready=0.
//   Their changes during RUN do not affect the result.
// - The sum, carry and overflow outputs keep their last value in IDLE
//   until the next result overwrites them.
// - NSLICE=1 is legal: a single RUN cycle, then DONE.
// - Wrap-around: the result is modulo 2^WIDTH; the carry reports the lost bit.
// TESTING
// T1 a=32'h0000_0001, b=32'h0000_0002, cin=0 -> after 4 cycles out_valid=1,
//    sum=32'h0000_0003, carry=0, overflow=0
// T2 a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0 -> sum=32'h0, carry=1,
//    overflow=0; the carry ripples through all 4 slices
// T3 a=32'h7FFF_FFFF, b=32'h0000_0000, cin=1 -> sum=32'h8000_0000,
//    carry=0, overflow=1
// T4 out_ready held 0 for 5 cycles in DONE -> sum/carry/overflow stable and
//    in_ready=0 throughout; on the out_ready=1 edge go to IDLE, in_ready=1 next cycle
// T5 rst_n=0 for 1 cycle in the 2nd RUN cycle -> next cycle out_valid=0,
//    sum=0, in_ready=1; a new op a=5, b=7 then returns sum=12
// T6 change a and b every cycle during RUN -> result equals the captured
//    operands only; back-to-back random ops match a+b+cin against a reference model

Source files
------------

// File: rtl/rca_seq_adder_if.sv
// Valid/ready operand and result ports of the sequential ripple-carry adder.
// The master drives the operands and out_ready; the slave is the adder.
interface rca_seq_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder: one SLICE-bit slice of a + b + carry_in per clock,
// with the carry between slices held in a register.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands; last result held on the outputs
// RUN   | one slice summed per cycle, slice index counts up to NSLICE-1
// DONE  | out_valid=1, result held until out_ready
module rca_seq_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rca_seq_adder_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE:0]   slice_res;

  always_comb begin
    slice_a   = a_q[idx*SLICE +: SLICE];
    slice_b   = b_q[idx*SLICE +: SLICE];
    slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx         <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            carry_q    <= bus.carry_in;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*SLICE +: SLICE] <= slice_res[SLICE-1:0];
          carry_q <= slice_res[SLICE];
          if (idx == LAST_IDX) begin
            // The top slice is being written now, so its MSB is the new sum sign.
            carry_out_q <= slice_res[SLICE];
            overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (slice_res[SLICE-1] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            idx         <= '0;
            state       <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_rca_seq_adder.sv
// Bench for rca_seq_adder: directed vectors plus a reference model feed an
// expected-result queue that a negedge monitor drains on every output handshake.
module tb_rca_seq_adder;
  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  rca_seq_adder_if #(.WIDTH(WIDTH)) bus ();

  rca_seq_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
    exp_t e;
    logic [WIDTH:0] full;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    e.s  = full[WIDTH-1:0];
    e.c  = full[WIDTH];
    e.o  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got sum %0h with no result expected", bus.sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum",      64'(bus.sum),      64'(e.s));
        check("carry",    64'(bus.carry),    64'(e.c));
        check("overflow", 64'(bus.overflow), 64'(e.o));
      end
    end
  end

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.in_ready !== 1'b1) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    wait_in_ready();
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Accept an op, push its expected result, and check out_valid rises exactly NSLICE cycles later.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                      input exp_t e, input bit scramble);
    accept(a, b, cin);
    exp_q.push_back(e);
    for (int i = 1; i <= NSLICE; i++) begin
      if (scramble && i < NSLICE) begin
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.carry_in = 1'($urandom_range(0, 1));
        bus.in_valid = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("latency_out_valid", 64'(bus.out_valid), 64'(i == NSLICE));
      check("busy_in_ready",     64'(bus.in_ready),  64'd0);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    int               n;

    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum",       64'(bus.sum),       64'd0);
    check("rst_carry",     64'(bus.carry),     64'd0);
    check("rst_overflow",  64'(bus.overflow),  64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // T1..T3: hand-computed vectors
    e = '{s: 32'h0000_0003, c: 1'b0, o: 1'b0};
    send(32'h0000_0001, 32'h0000_0002, 1'b0, e, 1'b0);
    e = '{s: 32'h0000_0000, c: 1'b1, o: 1'b0};
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, e, 1'b0);
    e = '{s: 32'h8000_0000, c: 1'b0, o: 1'b1};
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, e, 1'b0);

    // T4: consumer stalls in DONE
    wait_in_ready();
    bus.out_ready = 1'b0;
    e = '{s: 32'h2345_678A, c: 1'b0, o: 1'b0};
    send(32'h1234_5678, 32'h1111_1111, 1'b1, e, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready",  64'(bus.in_ready),  64'd0);
      check("hold_sum",       64'(bus.sum),       64'h2345_678A);
      check("hold_carry",     64'(bus.carry),     64'd0);
      check("hold_overflow",  64'(bus.overflow),  64'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready",  64'(bus.in_ready),  64'd1);
    check("release_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_sum_kept",     64'(bus.sum),       64'h2345_678A);

    // T5: reset in the second RUN cycle abandons the op
    accept(32'h0000_0009, 32'h0000_0009, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_sum",       64'(bus.sum),       64'd0);
    check("abort_in_ready",  64'(bus.in_ready),  64'd1);
    e = '{s: 32'd12, c: 1'b0, o: 1'b0};
    send(32'd5, 32'd7, 1'b0, e, 1'b0);

    // T6: operands wiggle during RUN; then back-to-back model-checked ops
    e = '{s: 32'h0000_0000, c: 1'b1, o: 1'b1};
    send(32'h8000_0000, 32'h8000_0000, 1'b0, e, 1'b1);
    e = '{s: 32'hFFFF_FFFF, c: 1'b0, o: 1'b0};
    send(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, e, 1'b1);
    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc), 1'(k % 2));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
